// File: rtl/audio_pkg.sv
// Shared audio-chain types: sample/envelope words, envelope FSM states.
// Imported by the envelope follower and its magnitude helper.
package audio_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic [15:0] env_t;
    typedef logic [14:0] mag_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } env_state_e;

    localparam sample_t SAMPLE_MAX = 16'sd32767;
    localparam sample_t SAMPLE_MIN = 16'sh8000;

endpackage

// File: rtl/abs_sat.sv
// Saturating magnitude: x (signed 16) -> mag (unsigned 15).
// Combinational; -32768 clips to 32767 so the result always fits in 15 bits.
module abs_sat
    import audio_pkg::*;
(
    input  sample_t x,
    output mag_t    mag
);

    always_comb begin
        mag = x[14:0];
        if (x == SAMPLE_MIN) begin
            mag = SAMPLE_MAX[14:0];
        end else if (x[15]) begin
            // two's-complement negate of the low bits is exact here
            mag = ~x[14:0] + 15'd1;
        end
    end

endmodule

// File: rtl/envelope_follower.sv
// Peak envelope follower with attack/hold/release and a hysteretic gate.
// In: clk, rst_n, en, sample_valid, audio_in. Out: env_out, env_valid, gate, state_out.
module envelope_follower
    import audio_pkg::*;
#(
    parameter int unsigned ATTACK_SHIFT  = 2,
    parameter int unsigned RELEASE_SHIFT = 8,
    parameter int unsigned HOLD_SAMPLES  = 256,
    parameter int unsigned GATE_ON       = 2048,
    parameter int unsigned GATE_OFF      = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sample_valid,
    input  sample_t    audio_in,
    output env_t       env_out,
    output logic       env_valid,
    output logic       gate,
    output logic [1:0] state_out
);

    localparam env_t HOLD_INIT  = env_t'(HOLD_SAMPLES - 1);
    localparam env_t GATE_ON_V  = env_t'(GATE_ON);
    localparam env_t GATE_OFF_V = env_t'(GATE_OFF);

    mag_t       mag;
    env_t       mag_w;

    env_state_e state_q, state_d;
    env_t       env_q, env_d;
    env_t       hold_q, hold_d;
    logic       gate_q, gate_d;
    logic       valid_q, valid_d;

    env_t       up_diff, dn_diff;
    env_t       up_step, dn_step;
    logic       holding;

    abs_sat u_abs (
        .x   (audio_in),
        .mag (mag)
    );

    assign mag_w   = {1'b0, mag};
    assign holding = (state_q == ATTACK)
                  || (state_q == HOLD);

    // Steps are derived from the difference, so
    // they can never carry env past mag.
    always_comb begin
        up_diff = mag_w - env_q;
        dn_diff = env_q - mag_w;
        up_step = up_diff >> ATTACK_SHIFT;
        dn_step = dn_diff >> RELEASE_SHIFT;
        if (up_step == '0) up_step = 16'd1;
        if (dn_step == '0) dn_step = 16'd1;
    end

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        hold_d  = hold_q;
        gate_d  = gate_q;
        valid_d = 1'b0;
        if (!en) begin
            state_d = IDLE;
            env_d   = '0;
            hold_d  = '0;
            gate_d  = 1'b0;
        end else if (sample_valid) begin
            valid_d = 1'b1;
            if (mag_w > env_q) begin
                env_d   = env_q + up_step;
                hold_d  = HOLD_INIT;
                state_d = ATTACK;
            end else if (holding && hold_q != '0) begin
                hold_d  = hold_q - 16'd1;
                state_d = HOLD;
            end else if (env_q > mag_w) begin
                env_d   = env_q - dn_step;
                state_d = RELEASE;
            end else begin
                state_d = (env_q == '0) ? IDLE : HOLD;
            end
            // gate looks at the updated envelope
            if (env_d >= GATE_ON_V) begin
                gate_d = 1'b1;
            end else if (env_d < GATE_OFF_V) begin
                gate_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            env_q   <= '0;
            hold_q  <= '0;
            gate_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            hold_q  <= hold_d;
            gate_q  <= gate_d;
            valid_q <= valid_d;
        end
    end

    assign env_out   = env_q;
    assign env_valid = valid_q;
    assign gate      = gate_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_envelope_follower.sv
// Self-checking bench for envelope_follower: reference model plus
// directed scenarios and randomized traffic.
module tb_envelope_follower;
    import audio_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       sample_valid;
    sample_t    audio_in;
    env_t       env_out;
    logic       env_valid;
    logic       gate;
    logic [1:0] state_out;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    // reference model state, plain integers
    int m_env, m_hold, m_state, m_gate, m_valid;

    envelope_follower dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sample_valid (sample_valid),
        .audio_in     (audio_in),
        .env_out      (env_out),
        .env_valid    (env_valid),
        .gate         (gate),
        .state_out    (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model of the rules: 0=IDLE 1=ATTACK 2=HOLD 3=RELEASE
    always @(posedge clk or negedge rst_n) begin
        int a, mag, step;
        if (!rst_n || !en) begin
            m_env = 0; m_hold = 0; m_state = 0;
            m_gate = 0; m_valid = 0;
        end else if (sample_valid) begin
            a = audio_in;
            mag = (a < 0) ? -a : a;
            if (mag > 32767) mag = 32767;
            if (mag > m_env) begin
                step = (mag - m_env) / 4;
                m_env += (step < 1) ? 1 : step;
                m_hold = 255;
                m_state = 1;
            end else if ((m_state == 1 || m_state == 2)
                         && m_hold != 0) begin
                m_hold -= 1;
                m_state = 2;
            end else if (m_env > mag) begin
                step = (m_env - mag) / 256;
                m_env -= (step < 1) ? 1 : step;
                m_state = 3;
            end else begin
                m_state = (m_env == 0) ? 0 : 2;
            end
            if (m_env >= 2048) m_gate = 1;
            else if (m_env < 1024) m_gate = 0;
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("env", int'(env_out), m_env);
            chk("gate", int'(gate), m_gate);
            chk("valid", int'(env_valid), m_valid);
            chk("state", int'(state_out), m_state);
        end
    end

    // one strobe, returns at the negedge where the result is visible
    task automatic send(input sample_t s);
        sample_valid = 1'b1;
        audio_in = s;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        int n, prev, r;
        bit seen;
        rst_n = 1'b0;
        en = 1'b0;
        sample_valid = 1'b0;
        audio_in = '0;
        repeat (3) @(negedge clk);
        chk_on = 1;
        chk("rst_env", int'(env_out), 0);
        chk("rst_gate", int'(gate), 0);
        chk("rst_valid", int'(env_valid), 0);
        chk("rst_state", int'(state_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;

        // attack toward 16000
        send(16'sd16000);
        chk("att_s1", int'(env_out), 4000);
        chk("att_gate", int'(gate), 1);
        send(16'sd16000);
        chk("att_s2", int'(env_out), 7000);
        prev = env_out;
        for (int i = 0; i < 18; i++) begin
            send(16'sd16000);
            chk("att_mono", int'(env_out >= prev), 1);
            chk("att_cap", int'(env_out <= 16000), 1);
            prev = env_out;
        end
        n = 0;
        while (env_out != 16000 && n < 200) begin
            send(16'sd16000);
            n++;
        end
        chk("att_reach", int'(env_out), 16000);

        // hold then release
        n = 0;
        while (state_out != RELEASE && n < 400) begin
            send(16'sd0);
            if (state_out != RELEASE)
                chk("hold_frozen", int'(env_out), 16000);
            n++;
        end
        chk("rel_state", int'(state_out), 3);
        chk("rel_first", int'(env_out), 15938);
        n = 0;
        seen = 0;
        while (state_out != IDLE && n < 3000) begin
            send(16'sd0);
            if (!seen && env_out < 1024) begin
                seen = 1;
                chk("gate_off", int'(gate), 0);
            end else if (!seen) begin
                chk("gate_held", int'(gate), 1);
            end
            n++;
        end
        chk("idle_env", int'(env_out), 0);
        chk("idle_state", int'(state_out), 0);

        // hysteresis
        n = 0;
        while (env_out != 1500 && n < 100) begin
            send(16'sd1500);
            n++;
        end
        chk("hyst_low_env", int'(env_out), 1500);
        chk("hyst_low_gate", int'(gate), 0);
        n = 0;
        while (env_out < 2048 && n < 20) begin
            send(16'sd3000);
            n++;
        end
        chk("hyst_on", int'(gate), 1);
        n = 0;
        while (env_out > 1600 && n < 1000) begin
            send(16'sd1500);
            n++;
        end
        chk("hyst_decay", int'(env_out <= 1600), 1);
        chk("hyst_kept", int'(gate), 1);

        // en drop mid-release
        n = 0;
        while (env_out < 12000 && n < 50) begin
            send(16'sd32767);
            n++;
        end
        n = 0;
        while (env_out > 10000 && n < 1000) begin
            send(-16'sd2);
            n++;
        end
        chk("en_pre_rel", int'(state_out), 3);
        en = 1'b0;
        sample_valid = 1'b1;
        audio_in = 16'sd5000;
        @(negedge clk);
        chk("en_env", int'(env_out), 0);
        chk("en_gate", int'(gate), 0);
        chk("en_state", int'(state_out), 0);
        chk("en_valid", int'(env_valid), 0);
        repeat (3) begin
            @(negedge clk);
            chk("en_strobe", int'(env_valid), 0);
        end
        sample_valid = 1'b0;
        en = 1'b1;
        @(negedge clk);

        // negative full scale
        for (int i = 0; i < 200; i++) begin
            send(SAMPLE_MIN);
            chk("nfs_cap", int'(env_out <= 32767), 1);
        end
        chk("nfs_final", int'(env_out), 32767);

        // randomized traffic, one async reset inside
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(99);
            en = (r < 2) ? 1'b0 : 1'b1;
            sample_valid = ($urandom_range(99) < 70);
            case ($urandom_range(3))
                0: audio_in = '0;
                1: audio_in = sample_t'($urandom_range(65535));
                2: audio_in = SAMPLE_MIN;
                default:
                    audio_in = sample_t'(
                        int'($urandom_range(6000)) - 3000);
            endcase
            if (i == 1500) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        sample_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
